// File: rtl/ring_pkg.sv
// Shared types for the slotted ring: message layout, ring-wide sizes and
// the per-stop throttle state encoding.
package ring_pkg;

    localparam int unsigned RING_NODES = 8;
    localparam int unsigned RING_PAY_W = 32;
    localparam int unsigned ID_W       = $clog2(RING_NODES);

    typedef struct packed {
        logic [ID_W-1:0]       dest;
        logic [ID_W-1:0]       src;
        logic [RING_PAY_W-1:0] payload;
    } ring_msg_t;

    typedef enum logic {
        RUN      = 1'b0,
        THROTTLE = 1'b1
    } stop_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: scans the request vector starting at the pointer
// and grants the first active requester (one-hot, or zero when idle).
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   gnt_idx_o
);

    logic             found_s;
    logic [PTR_W-1:0] cand_s;

    // Walk requesters in rotated order from ptr_i; the first active one wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found_s   = 1'b0;
        cand_s    = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand_s = PTR_W'((32'(ptr_i) + off) % NUM_REQ);
            if (!found_s && req_i[cand_s]) begin
                gnt_o[cand_s] = 1'b1;
                gnt_idx_o     = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/ring_stop_arbiter.sv
// One stop of a bufferless slotted ring: ejects messages addressed to this
// node, forwards everything else one cycle later, and injects local
// requests into free slots with round-robin fairness and a starvation
// throttle that asks the upstream stop to leave a slot empty.
module ring_stop_arbiter
    import ring_pkg::*;
#(
    parameter int unsigned NODE_ID      = 0,
    parameter int unsigned NUM_NODES    = 8,
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned PAY_W        = 32,
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       ring_in_valid,
    input  ring_msg_t                  ring_in_msg,
    output logic                       ring_out_valid,
    output ring_msg_t                  ring_out_msg,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  ring_msg_t [NUM_REQ-1:0]    req_msg,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       eject_valid,
    output ring_msg_t                  eject_msg,
    input  logic                       eject_ready,
    input  logic                       throttle_in,
    output logic                       throttle_out,
    output logic [15:0]                inject_cnt,
    output logic [15:0]                eject_cnt,
    output logic [15:0]                deflect_cnt,
    output logic                       bad_dest
);

    localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ID_W-1:0]     MY_ID      = ID_W'(NODE_ID % NUM_NODES);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [PTR_W-1:0]    LAST_REQ   = PTR_W'(NUM_REQ - 1);

    // The message type is fixed by ring_pkg; the ring sizing parameters must agree with it.
    if ((NUM_NODES != RING_NODES) || (PAY_W != RING_PAY_W)) begin : g_param_check
        $error("ring_stop_arbiter: NUM_NODES/PAY_W disagree with ring_pkg");
    end

    logic                eject_hit_s;
    logic                eject_take_s;
    logic                slot_free_s;
    logic                inj_ok_s;
    logic [NUM_REQ-1:0]  arb_req_s;
    logic [NUM_REQ-1:0]  arb_gnt_s;
    logic [PTR_W-1:0]    arb_idx_s;
    logic                gnt_any_s;
    ring_msg_t           sel_msg_s;

    logic                ring_out_valid_q, ring_out_valid_d;
    ring_msg_t           ring_out_msg_q,   ring_out_msg_d;
    logic [15:0]         inject_cnt_q,     inject_cnt_d;
    logic [15:0]         eject_cnt_q,      eject_cnt_d;
    logic [15:0]         deflect_cnt_q,    deflect_cnt_d;
    logic                bad_dest_q,       bad_dest_d;
    logic [PTR_W-1:0]    rr_ptr_q,         rr_ptr_d;
    logic [STARVE_W-1:0] starve_cnt_q,     starve_cnt_d;
    stop_state_e         state_q,          state_d;

    // Ejection and injection are suppressed while reset is held so nothing
    // is handed out or accepted that the reset would immediately discard.
    assign eject_hit_s  = rst_l && ring_in_valid && (ring_in_msg.dest == MY_ID);
    assign eject_take_s = eject_hit_s && eject_ready;
    assign slot_free_s  = !ring_in_valid || eject_take_s;
    assign inj_ok_s     = rst_l && slot_free_s && ((state_q == THROTTLE) || !throttle_in);
    assign arb_req_s    = req_valid & {NUM_REQ{inj_ok_s}};
    assign gnt_any_s    = |arb_gnt_s;
    assign sel_msg_s    = req_msg[arb_idx_s];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req_i     (arb_req_s),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (arb_gnt_s),
        .gnt_idx_o (arb_idx_s)
    );

    assign req_ready      = arb_gnt_s;
    assign eject_valid    = eject_hit_s;
    assign eject_msg      = ring_in_msg;
    assign ring_out_valid = ring_out_valid_q;
    assign ring_out_msg   = ring_out_msg_q;
    assign inject_cnt     = inject_cnt_q;
    assign eject_cnt      = eject_cnt_q;
    assign deflect_cnt    = deflect_cnt_q;
    assign bad_dest       = bad_dest_q;
    assign throttle_out   = (state_q == THROTTLE);

    // Next slot contents, event counters, fairness pointer and starvation FSM.
    always_comb begin
        ring_out_valid_d = 1'b0;
        ring_out_msg_d   = '0;
        inject_cnt_d     = inject_cnt_q;
        eject_cnt_d      = eject_cnt_q;
        deflect_cnt_d    = deflect_cnt_q;
        bad_dest_d       = bad_dest_q;
        rr_ptr_d         = rr_ptr_q;
        starve_cnt_d     = starve_cnt_q;
        state_d          = state_q;

        // A grant only happens on a free slot, so it never displaces pass-through.
        if (gnt_any_s) begin
            ring_out_valid_d = 1'b1;
            ring_out_msg_d   = sel_msg_s;
            inject_cnt_d     = inject_cnt_q + 16'd1;
            bad_dest_d       = bad_dest_q | (sel_msg_s.dest == MY_ID);
            rr_ptr_d         = (arb_idx_s == LAST_REQ) ? {PTR_W{1'b0}} : arb_idx_s + PTR_W'(1);
        end else if (ring_in_valid && !eject_take_s) begin
            ring_out_valid_d = 1'b1;
            ring_out_msg_d   = ring_in_msg;
        end else begin
            ring_out_valid_d = 1'b0;
            ring_out_msg_d   = '0;
        end

        if (eject_take_s) begin
            eject_cnt_d = eject_cnt_q + 16'd1;
        end else begin
            eject_cnt_d = eject_cnt_q;
        end

        if (eject_hit_s && !eject_ready) begin
            deflect_cnt_d = deflect_cnt_q + 16'd1;
        end else begin
            deflect_cnt_d = deflect_cnt_q;
        end

        if (gnt_any_s || !(|req_valid)) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end

        case (state_q)
            RUN:      state_d = (starve_cnt_d == STARVE_MAX) ? THROTTLE : RUN;
            THROTTLE: state_d = gnt_any_s ? RUN : THROTTLE;
            default:  state_d = RUN;
        endcase
    end

    // State register; reset drops any in-flight slot and clears all history.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ring_out_valid_q <= 1'b0;
            ring_out_msg_q   <= '0;
            inject_cnt_q     <= 16'd0;
            eject_cnt_q      <= 16'd0;
            deflect_cnt_q    <= 16'd0;
            bad_dest_q       <= 1'b0;
            rr_ptr_q         <= '0;
            starve_cnt_q     <= '0;
            state_q          <= RUN;
        end else begin
            ring_out_valid_q <= ring_out_valid_d;
            ring_out_msg_q   <= ring_out_msg_d;
            inject_cnt_q     <= inject_cnt_d;
            eject_cnt_q      <= eject_cnt_d;
            deflect_cnt_q    <= deflect_cnt_d;
            bad_dest_q       <= bad_dest_d;
            rr_ptr_q         <= rr_ptr_d;
            starve_cnt_q     <= starve_cnt_d;
            state_q          <= state_d;
        end
    end

endmodule

// File: doc/ring_stop_arbiter.md
RING_STOP_ARBITER -- requirements
Module: ring_stop_arbiter

Interface
REQ-001 Parameters SHALL be: NODE_ID, default 0, this stop's ring address; NUM_NODES, default 8, ring size; NUM_REQ, default 4, local requesters; PAY_W, default 32, payload bits; STARVE_LIMIT, default 16, blocked cycles before throttle.
REQ-002 Design SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_l  input  1  asynchronous active-low reset.
REQ-005 ring_in_valid / ring_in_msg  input  1 / ring_msg_t  slot arriving from upstream stop.
REQ-006 ring_out_valid / ring_out_msg  output  1 / ring_msg_t  registered slot to downstream stop.
REQ-007 req_valid / req_msg  input  NUM_REQ / NUM_REQ x ring_msg_t  local injection requests.
REQ-008 req_ready  output  NUM_REQ  one-hot-or-zero injection grant.
REQ-009 eject_valid / eject_msg  output  1 / ring_msg_t  message delivered to this node.
REQ-010 eject_ready  input  1  local sink can take eject this cycle.
REQ-011 throttle_in  input  1  downstream stop starved; suppress own injection.
REQ-012 throttle_out  output  1  this stop starved; registered request to upstream.
REQ-013 inject_cnt / eject_cnt / deflect_cnt  output  16 each  wrapping event counters.
REQ-014 bad_dest  output  1  sticky error: granted request had dest == NODE_ID.

Function
REQ-015 Ring is slotted and bufferless: no backpressure on ring_in; one slot per cycle.
REQ-016 eject_valid SHALL be combinational: ring_in_valid && ring_in_msg.dest == NODE_ID; eject_msg = ring_in_msg.
REQ-017 Eject takes effect when eject_valid && eject_ready; slot becomes free.
REQ-018 Message for NODE_ID with eject_ready low SHALL pass to ring_out next cycle (deflection); deflect_cnt +1.
REQ-019 Message for another node SHALL appear on ring_out exactly 1 cycle later, unmodified.
REQ-020 slot_free = !ring_in_valid || eject taken.
REQ-021 Injection allowed when slot_free && (state == THROTTLE || !throttle_in); pass-through always beats injection.
REQ-022 Among valid requesters, round-robin starting at pointer rr_ptr; winner i gets req_ready[i]=1 (combinational, same cycle); rr_ptr <= (i+1) mod NUM_REQ on grant; unchanged otherwise.
REQ-023 Granted message SHALL drive ring_out next cycle; inject_cnt +1.
REQ-024 Granted request with dest == NODE_ID SHALL still be injected and SHALL set bad_dest until reset.
REQ-025 starve_cnt: +1 per cycle with any req_valid and no grant, saturating at STARVE_LIMIT; cleared on grant or when no req_valid.
REQ-026 FSM RUN -> THROTTLE when starve_cnt reaches STARVE_LIMIT; THROTTLE -> RUN on first grant; throttle_out = (state == THROTTLE), registered.
REQ-027 In THROTTLE throttle_in SHALL be ignored (prevents mutual-throttle deadlock).
REQ-028 Simultaneous eject and grant in one cycle SHALL both occur; ring_out carries the injected message.
REQ-029 Counters wrap 0xFFFF -> 0x0000.

Reset
REQ-030 On rst_l low, asynchronously: ring_out_valid=0, ring_out_msg=0, throttle_out=0, bad_dest=0, counters=0, rr_ptr=0, starve_cnt=0, state=RUN.
REQ-031 req_ready and eject_valid SHALL be 0 while rst_l is low; reset mid-operation discards the in-flight ring_out slot.

Structure
REQ-032 Package ring_pkg SHALL hold ring_msg_t {dest, src, payload}, ID_W=$clog2(NUM_NODES), and the RUN/THROTTLE enum.
REQ-033 Round-robin selection SHALL be one sub-module rr_arbiter (req vector, pointer -> one-hot grant).

Verification
REQ-034 NODE_ID=2; ring_in dest=5 payload 0xA5 -> ring_out same message 1 cycle later, no grant that cycle.
REQ-035 ring_in dest=2, eject_ready=1, req_valid=4'b0001 -> eject same cycle, req_ready=4'b0001, ring_out=req_msg[0] next cycle.
REQ-036 ring_in dest=2, eject_ready=0 -> message on ring_out next cycle, deflect_cnt=1.
REQ-037 req_valid=4'b1111, empty ring, 4 cycles -> grants 0,1,2,3 in order; rr_ptr returns to 0.
REQ-038 Continuous pass-through traffic, req_valid[1]=1 for 16 cycles -> throttle_out=1 at cycle 17; first grant -> throttle_out=0 next cycle.
REQ-039 throttle_in=1, empty ring, req_valid=1 -> no grant until own THROTTLE entered, then grant despite throttle_in.
